// File: rtl/commit_if.sv
// Commit-stage bundle: per-lane completion info from the pipeline and the
// commit/flush/control results returned by commit_ctrl.
interface commit_if #(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned FTQ_SIZE     = 8,
  parameter int unsigned EXCP_W       = 16
);
  localparam int unsigned FTQ_IDW = $clog2(FTQ_SIZE);

  logic [COMMIT_WIDTH-1:0]         lane_valid_i;
  logic [COMMIT_WIDTH-1:0]         lane_excp_i;
  logic [COMMIT_WIDTH*EXCP_W-1:0]  lane_excp_num_i;
  logic [COMMIT_WIDTH-1:0]         lane_ertn_i;
  logic [COMMIT_WIDTH-1:0]         lane_idle_i;
  logic [COMMIT_WIDTH-1:0]         lane_pri_i;
  logic [COMMIT_WIDTH-1:0]         lane_last_i;
  logic [COMMIT_WIDTH*FTQ_IDW-1:0] lane_ftq_id_i;
  logic [COMMIT_WIDTH*32-1:0]      lane_pc_i;
  logic                            issue_pri_i;
  logic [COMMIT_WIDTH-1:0]         mem_stallreq_i;
  logic [COMMIT_WIDTH-1:0]         ex_stallreq_i;
  logic                            dispatch_stallreq_i;
  logic                            int_pending_i;

  logic [COMMIT_WIDTH-1:0]         commit_o;
  logic [COMMIT_WIDTH-1:0]         commit_block_o;
  logic                            flush_o;
  logic [FTQ_IDW-1:0]              flush_ftq_id_o;
  logic                            excp_o;
  logic                            ertn_o;
  logic [EXCP_W-1:0]               excp_num_o;
  logic [31:0]                     excp_pc_o;
  logic [31:0]                     era_o;
  logic [4:0]                      stall_o;
  logic                            pri_stall_o;
  logic                            frontend_halt_o;
  logic [31:0]                     instret_o;

  modport master (
    output lane_valid_i, lane_excp_i, lane_excp_num_i, lane_ertn_i, lane_idle_i,
           lane_pri_i, lane_last_i, lane_ftq_id_i, lane_pc_i, issue_pri_i,
           mem_stallreq_i, ex_stallreq_i, dispatch_stallreq_i, int_pending_i,
    input  commit_o, commit_block_o, flush_o, flush_ftq_id_o, excp_o, ertn_o,
           excp_num_o, excp_pc_o, era_o, stall_o, pri_stall_o, frontend_halt_o,
           instret_o
  );

  modport slave (
    input  lane_valid_i, lane_excp_i, lane_excp_num_i, lane_ertn_i, lane_idle_i,
           lane_pri_i, lane_last_i, lane_ftq_id_i, lane_pc_i, issue_pri_i,
           mem_stallreq_i, ex_stallreq_i, dispatch_stallreq_i, int_pending_i,
    output commit_o, commit_block_o, flush_o, flush_ftq_id_o, excp_o, ertn_o,
           excp_num_o, excp_pc_o, era_o, stall_o, pri_stall_o, frontend_halt_o,
           instret_o
  );
endinterface

// File: rtl/commit_ctrl.sv
// Commit controller: picks the oldest terminating lane, gates commits behind it,
// raises flush/exception info, and sequences privileged-serialise and idle waits.
module commit_ctrl #(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned FTQ_SIZE     = 8,
  parameter int unsigned EXCP_W       = 16
) (
  input  logic     clk,
  input  logic     rst,
  commit_if.slave  bus
);
  localparam int unsigned FTQ_IDW = $clog2(FTQ_SIZE);
  localparam int unsigned CNT_W   = $clog2(COMMIT_WIDTH + 1);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_PRI_WAIT  = 2'd1;
  localparam logic [1:0] ST_IDLE_WAIT = 2'd2;

  logic [1:0]              state;
  logic [1:0]              state_next;
  logic [COMMIT_WIDTH-1:0] commit;
  logic [COMMIT_WIDTH-1:0] commit_block;
  logic                    term_found;
  logic                    term_excp;
  logic                    term_ertn;
  logic                    term_idle;
  logic [EXCP_W-1:0]       term_excp_num;
  logic [FTQ_IDW-1:0]      term_ftq_id;
  logic [31:0]             term_pc;
  logic [CNT_W-1:0]        commit_cnt;
  logic                    excp;
  logic                    ertn;
  logic                    flush;
  logic                    pri_commit;
  logic                    idle_commit;
  logic [4:0]              stall;
  logic                    pri_stall;
  logic                    frontend_halt;
  logic [31:0]             instret;

  // Walk lanes oldest-first; everything after the first terminating lane is squashed.
  always_comb begin
    logic is_term;
    commit        = '0;
    commit_block  = '0;
    term_found    = 1'b0;
    term_excp     = 1'b0;
    term_ertn     = 1'b0;
    term_idle     = 1'b0;
    term_excp_num = '0;
    term_ftq_id   = '0;
    term_pc       = '0;
    commit_cnt    = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      is_term = bus.lane_valid_i[k] & ~term_found &
                (bus.lane_excp_i[k] | bus.lane_ertn_i[k] | bus.lane_idle_i[k]);
      commit[k]       = bus.lane_valid_i[k] & ~term_found & ~(is_term & bus.lane_excp_i[k]);
      commit_block[k] = bus.lane_valid_i[k] & ~term_found & (bus.lane_last_i[k] | is_term);
      if (is_term) begin
        term_excp     = bus.lane_excp_i[k];
        term_ertn     = bus.lane_ertn_i[k];
        term_idle     = bus.lane_idle_i[k];
        term_excp_num = bus.lane_excp_num_i[k*EXCP_W +: EXCP_W];
        term_ftq_id   = bus.lane_ftq_id_i[k*FTQ_IDW +: FTQ_IDW];
        term_pc       = bus.lane_pc_i[k*32 +: 32];
      end
      term_found = term_found | is_term;
      commit_cnt = commit_cnt + CNT_W'(commit[k]);
    end
  end

  assign excp        = term_found & term_excp;
  assign ertn        = term_found & term_ertn & ~term_excp;
  assign flush       = excp | ertn | (term_found & term_idle);
  assign pri_commit  = |(commit & bus.lane_pri_i);
  assign idle_commit = |(commit & bus.lane_idle_i);

  // Stall vector is combinational so reset can blank it within the same cycle.
  always_comb begin
    stall = 5'b00000;
    if (rst)
      stall = 5'b00000;
    else if ((|bus.mem_stallreq_i) | (|bus.ex_stallreq_i))
      stall = 5'b11110;
    else if (bus.dispatch_stallreq_i)
      stall = 5'b11100;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (excp | ertn) begin
      state_next = ST_RUN;
    end else if (idle_commit) begin
      state_next = ST_IDLE_WAIT;
    end else begin
      case (state)
        ST_RUN:       if (bus.issue_pri_i) state_next = ST_PRI_WAIT;
        ST_PRI_WAIT:  if (pri_commit && !bus.issue_pri_i) state_next = ST_RUN;
        ST_IDLE_WAIT: if (bus.int_pending_i) state_next = ST_RUN;
        default:      state_next = ST_RUN;
      endcase
    end
  end

  // Status flags track the upcoming state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_stall     <= 1'b0;
      frontend_halt <= 1'b0;
      instret       <= '0;
    end else begin
      pri_stall     <= (state_next == ST_PRI_WAIT);
      frontend_halt <= (state_next == ST_IDLE_WAIT);
      instret       <= instret + 32'(commit_cnt);
    end
  end

  assign bus.commit_o        = commit;
  assign bus.commit_block_o  = commit_block;
  assign bus.flush_o         = flush;
  assign bus.flush_ftq_id_o  = flush ? term_ftq_id : '0;
  assign bus.excp_o          = excp;
  assign bus.ertn_o          = ertn;
  assign bus.excp_num_o      = excp ? term_excp_num : '0;
  assign bus.excp_pc_o       = excp ? term_pc : 32'd0;
  assign bus.era_o           = !term_found ? 32'd0 : (term_idle ? term_pc + 32'd4 : term_pc);
  assign bus.stall_o         = stall;
  assign bus.pri_stall_o     = pri_stall;
  assign bus.frontend_halt_o = frontend_halt;
  assign bus.instret_o       = instret;
endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl with two lanes and hand-computed expectations.
module tb_commit_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  commit_if #(.COMMIT_WIDTH(2), .FTQ_SIZE(8), .EXCP_W(16)) bus ();

  commit_ctrl #(.COMMIT_WIDTH(2), .FTQ_SIZE(8), .EXCP_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.lane_valid_i = '0;  bus.lane_excp_i = '0;  bus.lane_excp_num_i = '0;
    bus.lane_ertn_i = '0;   bus.lane_idle_i = '0;  bus.lane_pri_i = '0;
    bus.lane_last_i = '0;   bus.lane_ftq_id_i = '0; bus.lane_pc_i = '0;
    bus.issue_pri_i = 1'b0; bus.mem_stallreq_i = '0; bus.ex_stallreq_i = '0;
    bus.dispatch_stallreq_i = 1'b0; bus.int_pending_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1; bus.mem_stallreq_i = 2'b11; bus.dispatch_stallreq_i = 1'b1;
    #1;
    total++; if (bus.stall_o !== 5'b00000) begin bad++; $display("FAIL reset_stall: got %b want 00000", bus.stall_o); end
    tick();
    total++; if (bus.pri_stall_o !== 1'b0) begin bad++; $display("FAIL reset_pri_stall: got %b want 0", bus.pri_stall_o); end
    total++; if (bus.frontend_halt_o !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b want 0", bus.frontend_halt_o); end
    total++; if (bus.instret_o !== 32'd0) begin bad++; $display("FAIL reset_instret: got %0d want 0", bus.instret_o); end
    @(negedge clk);
    rst = 1'b0; clear_inputs();
  endtask

  task automatic test_normal();
    @(negedge clk);
    clear_inputs();
    bus.lane_valid_i = 2'b11; bus.lane_last_i = 2'b10;
    bus.lane_pc_i = {32'h1c000004, 32'h1c000000};
    #1;
    total++; if (bus.commit_o !== 2'b11) begin bad++; $display("FAIL normal_commit: got %b want 11", bus.commit_o); end
    total++; if (bus.commit_block_o !== 2'b10) begin bad++; $display("FAIL normal_block: got %b want 10", bus.commit_block_o); end
    total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL normal_flush: got %b want 0", bus.flush_o); end
    total++; if (bus.era_o !== 32'd0) begin bad++; $display("FAIL normal_era: got %h want 0", bus.era_o); end
    tick();
    total++; if (bus.instret_o !== 32'd2) begin bad++; $display("FAIL normal_instret: got %0d want 2", bus.instret_o); end
  endtask

  task automatic test_excp();
    @(negedge clk);
    clear_inputs();
    bus.lane_valid_i = 2'b11; bus.lane_excp_i = 2'b01; bus.lane_last_i = 2'b10;
    bus.lane_excp_num_i = {16'h0004, 16'h0200};
    bus.lane_ftq_id_i = {3'd5, 3'd3};
    bus.lane_pc_i = {32'h1c000014, 32'h1c000010};
    #1;
    total++; if (bus.commit_o !== 2'b00) begin bad++; $display("FAIL excp_commit: got %b want 00", bus.commit_o); end
    total++; if (bus.commit_block_o !== 2'b01) begin bad++; $display("FAIL excp_block: got %b want 01", bus.commit_block_o); end
    total++; if (bus.excp_o !== 1'b1) begin bad++; $display("FAIL excp_flag: got %b want 1", bus.excp_o); end
    total++; if (bus.excp_num_o !== 16'h0200) begin bad++; $display("FAIL excp_num: got %h want 0200", bus.excp_num_o); end
    total++; if (bus.excp_pc_o !== 32'h1c000010) begin bad++; $display("FAIL excp_pc: got %h want 1c000010", bus.excp_pc_o); end
    total++; if (bus.flush_ftq_id_o !== 3'd3) begin bad++; $display("FAIL excp_ftq_id: got %0d want 3", bus.flush_ftq_id_o); end
    total++; if (bus.era_o !== 32'h1c000010) begin bad++; $display("FAIL excp_era: got %h want 1c000010", bus.era_o); end
    total++; if (bus.ertn_o !== 1'b0) begin bad++; $display("FAIL excp_ertn: got %b want 0", bus.ertn_o); end
    tick();
    total++; if (bus.instret_o !== 32'd2) begin bad++; $display("FAIL excp_instret: got %0d want 2", bus.instret_o); end
  endtask

  task automatic test_ertn();
    @(negedge clk);
    clear_inputs();
    bus.lane_valid_i = 2'b11; bus.lane_ertn_i = 2'b10;
    bus.lane_ftq_id_i = {3'd6, 3'd1};
    bus.lane_pc_i = {32'h00002000, 32'h00001ffc};
    #1;
    total++; if (bus.commit_o !== 2'b11) begin bad++; $display("FAIL ertn_commit: got %b want 11", bus.commit_o); end
    total++; if (bus.commit_block_o !== 2'b10) begin bad++; $display("FAIL ertn_block: got %b want 10", bus.commit_block_o); end
    total++; if (bus.ertn_o !== 1'b1) begin bad++; $display("FAIL ertn_flag: got %b want 1", bus.ertn_o); end
    total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL ertn_flush: got %b want 1", bus.flush_o); end
    total++; if (bus.flush_ftq_id_o !== 3'd6) begin bad++; $display("FAIL ertn_ftq_id: got %0d want 6", bus.flush_ftq_id_o); end
    total++; if (bus.excp_o !== 1'b0 || bus.excp_pc_o !== 32'd0) begin bad++; $display("FAIL ertn_no_excp: got excp=%b pc=%h want 0/0", bus.excp_o, bus.excp_pc_o); end
    total++; if (bus.era_o !== 32'h00002000) begin bad++; $display("FAIL ertn_era: got %h want 00002000", bus.era_o); end
    tick();
    total++; if (bus.instret_o !== 32'd4) begin bad++; $display("FAIL ertn_instret: got %0d want 4", bus.instret_o); end
  endtask

  task automatic test_pri();
    @(negedge clk);
    clear_inputs(); bus.issue_pri_i = 1'b1;
    tick();
    total++; if (bus.pri_stall_o !== 1'b1) begin bad++; $display("FAIL pri_enter: got %b want 1", bus.pri_stall_o); end
    @(negedge clk);
    clear_inputs();
    tick();
    total++; if (bus.pri_stall_o !== 1'b1) begin bad++; $display("FAIL pri_hold: got %b want 1", bus.pri_stall_o); end
    @(negedge clk);
    clear_inputs(); bus.lane_valid_i = 2'b01; bus.lane_pri_i = 2'b01; bus.issue_pri_i = 1'b1;
    tick();
    total++; if (bus.pri_stall_o !== 1'b1) begin bad++; $display("FAIL pri_reissue: got %b want 1", bus.pri_stall_o); end
    @(negedge clk);
    clear_inputs(); bus.lane_valid_i = 2'b01; bus.lane_pri_i = 2'b01;
    tick();
    total++; if (bus.pri_stall_o !== 1'b0) begin bad++; $display("FAIL pri_release: got %b want 0", bus.pri_stall_o); end
    total++; if (bus.instret_o !== 32'd6) begin bad++; $display("FAIL pri_instret: got %0d want 6", bus.instret_o); end
  endtask

  task automatic test_idle();
    @(negedge clk);
    clear_inputs();
    bus.lane_valid_i = 2'b01; bus.lane_idle_i = 2'b01;
    bus.lane_ftq_id_i = {3'd0, 3'd2}; bus.lane_pc_i = {32'h0, 32'h00000100};
    #1;
    total++; if (bus.era_o !== 32'h00000104) begin bad++; $display("FAIL idle_era: got %h want 00000104", bus.era_o); end
    total++; if (bus.commit_o !== 2'b01) begin bad++; $display("FAIL idle_commit: got %b want 01", bus.commit_o); end
    total++; if (bus.flush_o !== 1'b1 || bus.flush_ftq_id_o !== 3'd2) begin bad++; $display("FAIL idle_flush: got %b/%0d want 1/2", bus.flush_o, bus.flush_ftq_id_o); end
    tick();
    total++; if (bus.frontend_halt_o !== 1'b1) begin bad++; $display("FAIL idle_enter: got %b want 1", bus.frontend_halt_o); end
    @(negedge clk);
    clear_inputs();
    tick();
    total++; if (bus.frontend_halt_o !== 1'b1) begin bad++; $display("FAIL idle_hold: got %b want 1", bus.frontend_halt_o); end
    @(negedge clk);
    clear_inputs(); bus.int_pending_i = 1'b1;
    tick();
    total++; if (bus.frontend_halt_o !== 1'b0) begin bad++; $display("FAIL idle_wake: got %b want 0", bus.frontend_halt_o); end
    total++; if (bus.instret_o !== 32'd7) begin bad++; $display("FAIL idle_instret: got %0d want 7", bus.instret_o); end
  endtask

  task automatic test_stall_rst();
    @(negedge clk);
    clear_inputs(); bus.mem_stallreq_i = 2'b01; bus.dispatch_stallreq_i = 1'b1;
    #1;
    total++; if (bus.stall_o !== 5'b11110) begin bad++; $display("FAIL stall_mem: got %b want 11110", bus.stall_o); end
    bus.mem_stallreq_i = 2'b00;
    #1;
    total++; if (bus.stall_o !== 5'b11100) begin bad++; $display("FAIL stall_dispatch: got %b want 11100", bus.stall_o); end
    bus.dispatch_stallreq_i = 1'b0; bus.ex_stallreq_i = 2'b10;
    #1;
    total++; if (bus.stall_o !== 5'b11110) begin bad++; $display("FAIL stall_ex: got %b want 11110", bus.stall_o); end
    bus.ex_stallreq_i = 2'b00;
    #1;
    total++; if (bus.stall_o !== 5'b00000) begin bad++; $display("FAIL stall_none: got %b want 00000", bus.stall_o); end
    @(negedge clk);
    clear_inputs(); bus.lane_valid_i = 2'b01; bus.lane_idle_i = 2'b01;
    tick();
    total++; if (bus.frontend_halt_o !== 1'b1) begin bad++; $display("FAIL rst_idle_enter: got %b want 1", bus.frontend_halt_o); end
    @(negedge clk);
    clear_inputs(); rst = 1'b1; bus.lane_valid_i = 2'b11;
    tick();
    total++; if (bus.frontend_halt_o !== 1'b0) begin bad++; $display("FAIL rst_idle_exit: got %b want 0", bus.frontend_halt_o); end
    total++; if (bus.instret_o !== 32'd0) begin bad++; $display("FAIL rst_instret: got %0d want 0", bus.instret_o); end
    @(negedge clk);
    rst = 1'b0; clear_inputs(); bus.issue_pri_i = 1'b1;
    tick();
    total++; if (bus.pri_stall_o !== 1'b1) begin bad++; $display("FAIL rst_pri_enter: got %b want 1", bus.pri_stall_o); end
    @(negedge clk);
    clear_inputs(); rst = 1'b1;
    tick();
    total++; if (bus.pri_stall_o !== 1'b0) begin bad++; $display("FAIL rst_pri_exit: got %b want 0", bus.pri_stall_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_priority();
    // Idle in lane 0 squashes an excepting lane 1.
    @(negedge clk);
    clear_inputs();
    bus.lane_valid_i = 2'b11; bus.lane_idle_i = 2'b01; bus.lane_excp_i = 2'b10;
    bus.lane_excp_num_i = {16'h0001, 16'h0000}; bus.lane_ftq_id_i = {3'd7, 3'd1};
    bus.lane_pc_i = {32'h00000300, 32'h00000100};
    #1;
    total++; if (bus.commit_o !== 2'b01 || bus.commit_block_o !== 2'b01) begin bad++; $display("FAIL prio_squash: got %b/%b want 01/01", bus.commit_o, bus.commit_block_o); end
    total++; if (bus.excp_o !== 1'b0 || bus.excp_num_o !== 16'h0) begin bad++; $display("FAIL prio_no_excp: got %b/%h want 0/0000", bus.excp_o, bus.excp_num_o); end
    total++; if (bus.flush_o !== 1'b1 || bus.flush_ftq_id_o !== 3'd1 || bus.era_o !== 32'h104) begin bad++; $display("FAIL prio_idle_flush: got %b/%0d/%h want 1/1/00000104", bus.flush_o, bus.flush_ftq_id_o, bus.era_o); end
    tick();
    total++; if (bus.frontend_halt_o !== 1'b1) begin bad++; $display("FAIL prio_halt: got %b want 1", bus.frontend_halt_o); end
    // An exception while halted returns to RUN.
    @(negedge clk);
    clear_inputs();
    bus.lane_valid_i = 2'b01; bus.lane_excp_i = 2'b01;
    bus.lane_excp_num_i = {16'h0000, 16'h8000}; bus.lane_ftq_id_i = {3'd0, 3'd4};
    bus.lane_pc_i = {32'h0, 32'h00000500};
    #1;
    total++; if (bus.excp_num_o !== 16'h8000 || bus.flush_ftq_id_o !== 3'd4 || bus.commit_o !== 2'b00) begin bad++; $display("FAIL prio_excp: got %h/%0d/%b want 8000/4/00", bus.excp_num_o, bus.flush_ftq_id_o, bus.commit_o); end
    tick();
    total++; if (bus.frontend_halt_o !== 1'b0) begin bad++; $display("FAIL prio_excp_wake: got %b want 0", bus.frontend_halt_o); end
    // Flags on an invalid lane are ignored.
    @(negedge clk);
    clear_inputs();
    bus.lane_valid_i = 2'b10; bus.lane_excp_i = 2'b01; bus.lane_last_i = 2'b10;
    #1;
    total++; if (bus.commit_o !== 2'b10 || bus.commit_block_o !== 2'b10) begin bad++; $display("FAIL prio_invalid: got %b/%b want 10/10", bus.commit_o, bus.commit_block_o); end
    total++; if (bus.flush_o !== 1'b0 || bus.excp_o !== 1'b0) begin bad++; $display("FAIL prio_invalid_flush: got %b/%b want 0/0", bus.flush_o, bus.excp_o); end
    tick();
    total++; if (bus.instret_o !== 32'd2) begin bad++; $display("FAIL prio_instret: got %0d want 2", bus.instret_o); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_normal();
    test_excp();
    test_ertn();
    test_pri();
    test_idle();
    test_stall_rst();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/commit_ctrl.md
COMMIT_CTRL -- requirements
Module: commit_ctrl

Interface
REQ-001 Parameter COMMIT_WIDTH, default 2, number of commit lanes (legal 1..4); lane 0 is oldest.
REQ-002 Parameter FTQ_SIZE, default 8, FTQ depth; FTQ_IDW = clog2(FTQ_SIZE).
REQ-003 Parameter EXCP_W, default 16, width of the one-hot exception vector; bit 0 has highest priority.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 lane_valid_i  in  COMMIT_WIDTH  lane holds a completed instruction.
REQ-007 lane_excp_i  in  COMMIT_WIDTH  lane instruction raised an exception.
REQ-008 lane_excp_num_i  in  COMMIT_WIDTH*EXCP_W  per-lane one-hot exception causes.
REQ-009 lane_ertn_i, lane_idle_i, lane_pri_i  in  COMMIT_WIDTH each  ertn / idle / serialising-privileged flags.
REQ-010 lane_last_i  in  COMMIT_WIDTH  lane is the last instruction of its basic block.
REQ-011 lane_ftq_id_i  in  COMMIT_WIDTH*FTQ_IDW  per-lane FTQ id.
REQ-012 lane_pc_i  in  COMMIT_WIDTH*32  per-lane PC.
REQ-013 issue_pri_i  in  1  dispatch is issuing a privileged instruction this cycle.
REQ-014 mem_stallreq_i, ex_stallreq_i  in  COMMIT_WIDTH each; dispatch_stallreq_i  in  1.
REQ-015 int_pending_i  in  1  enabled interrupt pending (wakes IDLE).
REQ-016 commit_o  out  COMMIT_WIDTH  per-lane architectural commit enable (regfile/CSR/difftest).
REQ-017 commit_block_o  out  COMMIT_WIDTH  per-lane basic-block retire to the FTQ.
REQ-018 flush_o  out  1; flush_ftq_id_o  out  FTQ_IDW; excp_o  out  1; ertn_o  out  1.
REQ-019 excp_num_o  out  EXCP_W; excp_pc_o  out  32  cause and PC of the winning exception lane.
REQ-020 era_o  out  32  exception return address.
REQ-021 stall_o  out  5  {mem_wb, ex_mem, dispatch_ex, id_dispatch, unused}.
REQ-022 pri_stall_o  out  1; frontend_halt_o  out  1; instret_o  out  32.

Function
REQ-023 The terminating lane t SHALL be the lowest k with lane_valid_i[k] & (lane_excp_i[k] | lane_ertn_i[k] | lane_idle_i[k]); t = none if no such lane exists.
REQ-024 commit_o[k] SHALL be lane_valid_i[k] & (k<t | (k==t & ~lane_excp_i[k])); all lanes above t SHALL be squashed.
REQ-025 commit_block_o[k] SHALL be 1 when lane k is valid and k<=t (or t = none), and either lane_last_i[k]=1 or k==t.
REQ-026 excp_o SHALL be lane_excp_i[t]; ertn_o SHALL be lane_ertn_i[t] & ~lane_excp_i[t].
REQ-027 flush_o SHALL be excp_o | ertn_o | (t is an idle lane).
REQ-028 flush_ftq_id_o SHALL be lane_ftq_id_i[t] when flush_o=1, else 0.
REQ-029 excp_num_o and excp_pc_o SHALL take lane t's values when excp_o=1, else 0.
REQ-030 era_o SHALL be lane_pc_i[t]+4 (mod 2^32) for an idle lane, else lane_pc_i[t]; era_o SHALL be 0 when t = none.
REQ-031 All commit, flush and exception outputs SHALL be combinational, same cycle as the inputs.
REQ-032 stall_o SHALL be 5'b11110 if any mem or ex stall request is set; else 5'b11100 if dispatch_stallreq_i=1; else 5'b00000.
REQ-033 The FSM SHALL have states RUN, PRI_WAIT and IDLE_WAIT, with reset state RUN.
REQ-034 Transition rules, highest priority first:
- in any state, flush_o from excp/ertn -> RUN;
- a committing idle lane -> IDLE_WAIT;
- RUN with issue_pri_i -> PRI_WAIT;
- PRI_WAIT, any commit_o[k] with lane_pri_i[k] -> RUN, unless issue_pri_i is also set (stay in PRI_WAIT);
- IDLE_WAIT with int_pending_i -> RUN.
REQ-035 pri_stall_o SHALL be registered and equal 1 exactly while the FSM is in PRI_WAIT.
REQ-036 frontend_halt_o SHALL be registered and equal 1 exactly while the FSM is in IDLE_WAIT.
REQ-037 instret_o SHALL add popcount(commit_o) every cycle and wrap modulo 2^32.

Reset
REQ-038 On rst, the FSM SHALL go to RUN and pri_stall_o, frontend_halt_o and instret_o SHALL be 0, and stall_o SHALL be forced to 0 in the same cycle.
REQ-039 Reset asserted during PRI_WAIT or IDLE_WAIT SHALL return the FSM to RUN on the next edge, with no commit or flush counted.

Verification
REQ-040 Two lanes valid, no flags, lane_last_i=2'b10 -> commit_o=2'b11, commit_block_o=2'b10, flush_o=0, instret_o+=2.
REQ-041 Lane0 excp_num=16'h0200, pc=0x1c000010 -> commit_o=00, commit_block_o=01, excp_o=1, excp_pc_o=0x1c000010, flush_ftq_id_o=lane0 id.
REQ-042 Lane1 ertn only -> commit_o=11, commit_block_o[1]=1, ertn_o=1, flush_o=1, flush_ftq_id_o=lane1 id.
REQ-043 issue_pri_i pulse -> pri_stall_o=1 next cycle and held; a pri lane commit -> 0 next cycle; pri commit together with issue_pri_i -> stays 1.
REQ-044 Lane0 idle, pc=0x100 -> era_o=0x104, commit_o=01, frontend_halt_o=1 from next cycle until int_pending_i=1, then 0 next cycle.
REQ-045 mem_stallreq_i=01 with dispatch_stallreq_i=1 -> stall_o=11110; rst during IDLE_WAIT -> frontend_halt_o=0 next cycle.
